// File: rtl/div_share_ctrl_if.sv
// Request/response bundle between the two divide requesters and div_share_ctrl.
// Requester 0: integer DIV/DIVU/REM/REMU; requester 1: FPU mantissa divide/sqrt step.
interface div_share_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic [1:0]       req_i;
    logic [WIDTH-1:0] dividend0_i;
    logic [WIDTH-1:0] divisor0_i;
    logic             signed0_i;
    logic             rem0_i;
    logic [WIDTH-1:0] dividend1_i;
    logic [WIDTH-1:0] divisor1_i;
    logic             signed1_i;
    logic             rem1_i;
    logic             flush0_i;
    logic [1:0]       grant_o;
    logic             busy_o;
    logic [1:0]       done_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output req_i, dividend0_i, divisor0_i, signed0_i, rem0_i,
               dividend1_i, divisor1_i, signed1_i, rem1_i, flush0_i,
        input  grant_o, busy_o, done_o, result_o
    );

    modport slave (
        input  req_i, dividend0_i, divisor0_i, signed0_i, rem0_i,
               dividend1_i, divisor1_i, signed1_i, rem1_i, flush0_i,
        output grant_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/div_share_ctrl.sv
// Shared iterative radix-2 restoring divider with round-robin arbitration
// between two requesters and RISC-V sign / corner-case handling.
// Optional macro DIV_SHARE_EARLY_OUT_EN: skip the iteration when the divisor
// is zero or its magnitude exceeds the dividend magnitude.
module div_share_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic clk_i,
    input  logic reset_i,
    div_share_ctrl_if.slave bus
);
    localparam int unsigned DW = 2 * WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_rr;
    logic             r_owner;
    logic             r_rem;
    logic             r_qneg;
    logic             r_rneg;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_dvs;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_quot;

    logic [1:0]       w_elig;
    logic [1:0]       w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_dvd;
    logic [WIDTH-1:0] w_dvs;
    logic             w_sgn;
    logic             w_rem;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_dvs_zero;
    logic             w_early;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_res;
    logic             w_flush_own;

    // Arbitration: a flushed requester 0 is not eligible; ties go to the rr side.
    assign w_elig   = bus.req_i & {1'b1, ~bus.flush0_i};
    assign w_grant  = (w_elig == 2'b11) ? (r_rr ? 2'b10 : 2'b01) : w_elig;
    assign w_accept = (r_state == S_IDLE) && (w_elig != 2'b00);

    // Operand selection and magnitude extraction for the granted requester.
    assign w_dvd      = w_grant[1] ? bus.dividend1_i : bus.dividend0_i;
    assign w_dvs      = w_grant[1] ? bus.divisor1_i  : bus.divisor0_i;
    assign w_sgn      = w_grant[1] ? bus.signed1_i   : bus.signed0_i;
    assign w_rem      = w_grant[1] ? bus.rem1_i      : bus.rem0_i;
    assign w_dvd_neg  = w_sgn & w_dvd[WIDTH-1];
    assign w_dvs_neg  = w_sgn & w_dvs[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -w_dvd : w_dvd;
    assign w_dvs_mag  = w_dvs_neg ? -w_dvs : w_dvs;
    assign w_dvs_zero = (w_dvs == '0);

`ifdef DIV_SHARE_EARLY_OUT_EN
    assign w_early = w_dvs_zero || (w_dvs_mag > w_dvd_mag);
`else
    assign w_early = 1'b0;
`endif

    // Restoring step: the shifted divisor only fits when its upper half is clear.
    assign w_ge  = (r_dvs[DW-1:WIDTH] == '0) && (r_part >= r_dvs[WIDTH-1:0]);
    assign w_sub = r_part - r_dvs[WIDTH-1:0];

    // Sign correction; /0 and overflow results fall out of the magnitudes directly.
    assign w_q   = r_qneg ? -r_quot : r_quot;
    assign w_r   = r_rneg ? -r_part : r_part;
    assign w_res = r_rem ? w_r : w_q;

    assign w_flush_own = ~r_owner & bus.flush0_i;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_elig != 2'b00) begin
                    w_next = w_early ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_flush_own) begin
                    w_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: combinational grant in IDLE, done pulse and result in DONE.
    always_comb begin
        bus.grant_o  = '0;
        bus.busy_o   = (r_state != S_IDLE);
        bus.done_o   = '0;
        bus.result_o = '0;
        if ((r_state == S_IDLE) && !reset_i) begin
            bus.grant_o = w_grant;
        end
        if ((r_state == S_DONE) && !w_flush_own) begin
            bus.done_o[r_owner] = 1'b1;
            bus.result_o        = w_res;
        end
    end

    // Datapath: capture on acceptance, one restoring step per RUN cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rr    <= 1'b0;
            r_owner <= 1'b0;
            r_rem   <= 1'b0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_cnt   <= '0;
            r_dvs   <= '0;
            r_part  <= '0;
            r_quot  <= '0;
        end else if (w_accept) begin
            r_owner <= w_grant[1];
            r_rem   <= w_rem;
            r_qneg  <= (w_dvd_neg ^ w_dvs_neg) & ~w_dvs_zero;
            r_rneg  <= w_dvd_neg;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_dvs   <= {w_dvs_mag, {(WIDTH-1){1'b0}}};
            r_part  <= w_dvd_mag;
            r_quot  <= '0;
            if (w_elig == 2'b11) begin
                r_rr <= ~r_rr;
            end
`ifdef DIV_SHARE_EARLY_OUT_EN
            if (w_early) begin
                r_quot <= w_dvs_zero ? '1 : '0;
            end
`endif
        end else if (r_state == S_RUN) begin
            if (w_ge) begin
                r_part <= w_sub;
            end
            r_quot <= {r_quot[WIDTH-2:0], w_ge};
            r_dvs  <= r_dvs >> 1;
            r_cnt  <= r_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl: expected results are queued at grant
// and compared when done_o pulses.
module tb_div_share_ctrl;
    localparam int unsigned W = 32;
`ifdef DIV_SHARE_EARLY_OUT_EN
    localparam int EL = 1;
`else
    localparam int EL = 33;
`endif

    typedef struct { logic [1:0] who; logic [W-1:0] res; int lat; } exp_t;
    typedef struct {
        int unsigned id; logic [W-1:0] a; logic [W-1:0] b;
        logic s; logic r; logic [W-1:0] exp; int lat;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_share_ctrl_if #(.WIDTH(W)) bus ();

    div_share_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic r);
        logic [W-1:0] q, m;
        if (b == '0) begin
            q = '1; m = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; m = '0;
        end else if (s) begin
            q = W'($signed(a) / $signed(b)); m = W'($signed(a) % $signed(b));
        end else begin
            q = a / b; m = a % b;
        end
        return r ? m : q;
    endfunction

    // Drive one request and wait (bounded) for its grant; returns after the acceptance edge.
    task automatic issue(input int unsigned id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic r, output logic ok);
        logic [1:0] m;
        m = (id == 0) ? 2'b01 : 2'b10;
        if (id == 0) begin
            bus.dividend0_i = a; bus.divisor0_i = b; bus.signed0_i = s; bus.rem0_i = r;
        end else begin
            bus.dividend1_i = a; bus.divisor1_i = b; bus.signed1_i = s; bus.rem1_i = r;
        end
        bus.req_i = bus.req_i | m;
        ok = 1'b0;
        #1;
        for (int n = 0; n < 100; n++) begin
            if ((bus.grant_o & m) != 2'b00) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (ok) begin @(posedge clk); #1; end
        bus.req_i = bus.req_i & ~m;
    endtask

    // Wait (bounded) for a done pulse; lat counts cycles after the grant cycle.
    task automatic wait_done(output logic [1:0] d, output logic [W-1:0] res, output int lat);
        d = '0; res = '0; lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk); #1;
            if (bus.done_o != 2'b00) begin d = bus.done_o; res = bus.result_o; lat = n; break; end
        end
    endtask

    task automatic run_op(input op_t o, output logic ok, output logic [1:0] d,
                          output logic [W-1:0] res, output int lat);
        issue(o.id, o.a, o.b, o.s, o.r, ok);
        d = '0; res = '0; lat = -1;
        if (ok) begin
            sb.push_back(exp_t'{who: (o.id == 0) ? 2'b01 : 2'b10, res: o.exp, lat: o.lat});
            wait_done(d, res, lat);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_i = 2'b11;
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin failures++; $display("FAIL reset_grant got %b want 00", bus.grant_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.done_o !== 2'b00) begin failures++; $display("FAIL reset_done got %b want 00", bus.done_o); end
        checks++; if (bus.result_o !== '0) begin failures++; $display("FAIL reset_result got %h want 0", bus.result_o); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (bus.grant_o !== 2'b01) begin failures++; $display("FAIL reset_rr_grant got %b want 01", bus.grant_o); end
        bus.req_i = 2'b00;
        @(posedge clk); #1;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL withdraw_busy got %b want 0", bus.busy_o); end
    endtask

    task automatic test_arith();
        op_t t [8];
        logic ok; logic [1:0] d; logic [W-1:0] res; int lat; exp_t e;
        t[0] = '{0, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 33};
        t[1] = '{0, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 33};
        t[2] = '{1, 32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0, 32'h0FFF_FFFF, 33};
        t[3] = '{1, 32'hFFFF_FFFF, 32'd16, 1'b0, 1'b1, 32'd15, 33};
        t[4] = '{1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 33};
        t[5] = '{1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 33};
        t[6] = '{0, 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0, 32'hFFFF_FFF2, 33};
        t[7] = '{0, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 33};
        foreach (t[i]) begin
            run_op(t[i], ok, d, res, lat);
            checks++;
            if (!ok) begin failures++; $display("FAIL arith[%0d]_grant none within bound", i); end
            else begin
                e = sb.pop_front();
                checks++; if (d !== e.who) begin failures++; $display("FAIL arith[%0d]_done got %b want %b", i, d, e.who); end
                checks++; if (res !== e.res) begin failures++; $display("FAIL arith[%0d]_result got %h want %h", i, res, e.res); end
                checks++; if (lat != e.lat) begin failures++; $display("FAIL arith[%0d]_latency got %0d want %0d", i, lat, e.lat); end
            end
        end
    endtask

    task automatic test_corner();
        op_t t [6];
        logic ok; logic [1:0] d; logic [W-1:0] res; int lat; exp_t e;
        t[0] = '{0, 32'd5, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, EL};
        t[1] = '{0, 32'd5, 32'd0, 1'b1, 1'b1, 32'd5, EL};
        t[2] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 33};
        t[3] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 33};
        t[4] = '{0, 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFB, EL};
        t[5] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, EL};
        foreach (t[i]) begin
            run_op(t[i], ok, d, res, lat);
            checks++;
            if (!ok) begin failures++; $display("FAIL corner[%0d]_grant none within bound", i); end
            else begin
                e = sb.pop_front();
                checks++; if (d !== e.who) begin failures++; $display("FAIL corner[%0d]_done got %b want %b", i, d, e.who); end
                checks++; if (res !== e.res) begin failures++; $display("FAIL corner[%0d]_result got %h want %h", i, res, e.res); end
                checks++; if (lat != e.lat) begin failures++; $display("FAIL corner[%0d]_latency got %0d want %0d", i, lat, e.lat); end
            end
        end
    endtask

    task automatic test_early();
        op_t t [4];
        logic ok; logic [1:0] d; logic [W-1:0] res; int lat; exp_t e;
        t[0] = '{0, 32'd3, 32'd10, 1'b0, 1'b0, 32'd0, EL};
        t[1] = '{0, 32'd3, 32'd10, 1'b0, 1'b1, 32'd3, EL};
        t[2] = '{1, 32'hFFFF_FFFD, 32'd10, 1'b1, 1'b0, 32'd0, EL};
        t[3] = '{1, 32'hFFFF_FFFD, 32'd10, 1'b1, 1'b1, 32'hFFFF_FFFD, EL};
        foreach (t[i]) begin
            run_op(t[i], ok, d, res, lat);
            checks++;
            if (!ok) begin failures++; $display("FAIL early[%0d]_grant none within bound", i); end
            else begin
                e = sb.pop_front();
                checks++; if (d !== e.who) begin failures++; $display("FAIL early[%0d]_done got %b want %b", i, d, e.who); end
                checks++; if (res !== e.res) begin failures++; $display("FAIL early[%0d]_result got %h want %h", i, res, e.res); end
                checks++; if (lat != e.lat) begin failures++; $display("FAIL early[%0d]_latency got %0d want %0d", i, lat, e.lat); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int gbad; int n; logic [1:0] d; logic [W-1:0] res; int lat; exp_t e;
        pulse_reset();
        bus.dividend0_i = 32'd100; bus.divisor0_i = 32'd7; bus.signed0_i = 1'b0; bus.rem0_i = 1'b0;
        bus.dividend1_i = 32'hFFFF_FFF9; bus.divisor1_i = 32'd2; bus.signed1_i = 1'b1; bus.rem1_i = 1'b0;
        bus.req_i = 2'b11;
        #1;
        checks++; if (bus.grant_o !== 2'b01) begin failures++; $display("FAIL b2b_first_grant got %b want 01", bus.grant_o); end
        sb.push_back(exp_t'{who: 2'b01, res: 32'd14, lat: 33});
        @(posedge clk); #1;
        bus.req_i = 2'b10;
        gbad = 0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk); #1;
            if (bus.grant_o !== 2'b00) gbad++;
            if (bus.done_o != 2'b00) break;
        end
        e = sb.pop_front();
        checks++; if (bus.done_o !== e.who) begin failures++; $display("FAIL b2b_done0 got %b want %b", bus.done_o, e.who); end
        checks++; if (bus.result_o !== e.res) begin failures++; $display("FAIL b2b_result0 got %h want %h", bus.result_o, e.res); end
        checks++; if (n != e.lat) begin failures++; $display("FAIL b2b_latency0 got %0d want %0d", n, e.lat); end
        checks++; if (gbad != 0) begin failures++; $display("FAIL b2b_busy_grant got %0d cycles want 0", gbad); end
        @(negedge clk); #1;
        checks++; if (bus.grant_o !== 2'b10) begin failures++; $display("FAIL b2b_second_grant got %b want 10", bus.grant_o); end
        sb.push_back(exp_t'{who: 2'b10, res: 32'hFFFF_FFFD, lat: 33});
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        wait_done(d, res, lat);
        e = sb.pop_front();
        checks++; if (d !== e.who) begin failures++; $display("FAIL b2b_done1 got %b want %b", d, e.who); end
        checks++; if (res !== e.res) begin failures++; $display("FAIL b2b_result1 got %h want %h", res, e.res); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL b2b_latency1 got %0d want %0d", lat, e.lat); end
    endtask

    task automatic test_flush();
        logic ok; logic [1:0] d; logic [W-1:0] res; int lat; exp_t e;
        // Flush owner 0 mid-RUN with requester 1 pending.
        issue(0, 32'd100, 32'd7, 1'b0, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL flush_run_grant none within bound"); end
        bus.dividend1_i = 32'd20; bus.divisor1_i = 32'd3; bus.signed1_i = 1'b0; bus.rem1_i = 1'b0;
        bus.req_i = 2'b10;
        repeat (10) @(negedge clk);
        bus.flush0_i = 1'b1;
        @(negedge clk);
        bus.flush0_i = 1'b0;
        #1;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL flush_run_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.done_o !== 2'b00) begin failures++; $display("FAIL flush_run_done got %b want 00", bus.done_o); end
        checks++; if (bus.grant_o !== 2'b10) begin failures++; $display("FAIL flush_pending_grant got %b want 10", bus.grant_o); end
        sb.push_back(exp_t'{who: 2'b10, res: 32'd6, lat: 33});
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        wait_done(d, res, lat);
        e = sb.pop_front();
        checks++; if (d !== e.who) begin failures++; $display("FAIL flush_pending_done got %b want %b", d, e.who); end
        checks++; if (res !== e.res) begin failures++; $display("FAIL flush_pending_result got %h want %h", res, e.res); end
        // Flush owner 0 during its DONE cycle.
        @(negedge clk);
        issue(0, 32'd100, 32'd7, 1'b0, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL flush_done_grant none within bound"); end
        repeat (32) @(posedge clk);
        #1; bus.flush0_i = 1'b1; #1;
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL flush_done_state got busy %b want 1", bus.busy_o); end
        checks++; if (bus.done_o !== 2'b00) begin failures++; $display("FAIL flush_done_pulse got %b want 00", bus.done_o); end
        checks++; if (bus.result_o !== '0) begin failures++; $display("FAIL flush_done_result got %h want 0", bus.result_o); end
        @(posedge clk); #1;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL flush_done_idle got busy %b want 0", bus.busy_o); end
        // Flush held through an owner-1 op has no effect.
        issue(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, ok);
        bus.flush0_i = 1'b1;
        checks++;
        if (!ok) begin failures++; $display("FAIL flush_own1_grant none within bound"); end
        else begin
            sb.push_back(exp_t'{who: 2'b10, res: 32'hFFFF_FFFD, lat: 33});
            wait_done(d, res, lat);
            e = sb.pop_front();
            checks++; if (d !== e.who) begin failures++; $display("FAIL flush_own1_done got %b want %b", d, e.who); end
            checks++; if (res !== e.res) begin failures++; $display("FAIL flush_own1_result got %h want %h", res, e.res); end
            checks++; if (lat != e.lat) begin failures++; $display("FAIL flush_own1_latency got %0d want %0d", lat, e.lat); end
        end
        bus.flush0_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        op_t o; logic ok; logic [1:0] d; logic [W-1:0] res; int lat; exp_t e;
        for (int i = 0; i < 8; i++) begin
            o.id = i % 2;
            o.s  = 1'(($urandom_range(0, 1)));
            o.r  = 1'(($urandom_range(0, 1)));
            o.a  = $urandom_range(2000, 32'h7FFF_FFFF);
            o.b  = $urandom_range(1, 1000);
            if ($urandom_range(0, 1) == 1) o.a = o.s ? -o.a : (o.a | 32'h8000_0000);
            if (o.s && $urandom_range(0, 1) == 1) o.b = -o.b;
            o.exp = model(o.a, o.b, o.s, o.r);
            o.lat = 33;
            run_op(o, ok, d, res, lat);
            checks++;
            if (!ok) begin failures++; $display("FAIL rand[%0d]_grant none within bound", i); end
            else begin
                e = sb.pop_front();
                checks++; if (d !== e.who) begin failures++; $display("FAIL rand[%0d]_done got %b want %b", i, d, e.who); end
                checks++; if (res !== e.res) begin failures++; $display("FAIL rand[%0d]_result a=%h b=%h s=%b r=%b got %h want %h", i, o.a, o.b, o.s, o.r, res, e.res); end
                checks++; if (lat != e.lat) begin failures++; $display("FAIL rand[%0d]_latency got %0d want %0d", i, lat, e.lat); end
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [1:0] d; logic [W-1:0] res; int lat; exp_t e;
        pulse_reset();
        bus.dividend0_i = 32'd100; bus.divisor0_i = 32'd7; bus.signed0_i = 1'b0; bus.rem0_i = 1'b0;
        bus.dividend1_i = 32'd20;  bus.divisor1_i = 32'd3; bus.signed1_i = 1'b0; bus.rem1_i = 1'b0;
        bus.req_i = 2'b11;
        #1;
        checks++; if (bus.grant_o !== 2'b01) begin failures++; $display("FAIL midrun_first_grant got %b want 01", bus.grant_o); end
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        repeat (5) @(negedge clk);
        rst = 1'b1; #1;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL midrun_reset_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.done_o !== 2'b00) begin failures++; $display("FAIL midrun_reset_done got %b want 00", bus.done_o); end
        @(negedge clk);
        rst = 1'b0;
        bus.req_i = 2'b11;
        #1;
        checks++; if (bus.grant_o !== 2'b01) begin failures++; $display("FAIL midrun_rr_restored got %b want 01", bus.grant_o); end
        sb.push_back(exp_t'{who: 2'b01, res: 32'd14, lat: 33});
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        wait_done(d, res, lat);
        e = sb.pop_front();
        checks++; if (d !== e.who) begin failures++; $display("FAIL midrun_done got %b want %b", d, e.who); end
        checks++; if (res !== e.res) begin failures++; $display("FAIL midrun_result got %h want %h", res, e.res); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL midrun_latency got %0d want %0d", lat, e.lat); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_i = 2'b00; bus.flush0_i = 1'b0;
        bus.dividend0_i = '0; bus.divisor0_i = '0; bus.signed0_i = 1'b0; bus.rem0_i = 1'b0;
        bus.dividend1_i = '0; bus.divisor1_i = '0; bus.signed1_i = 1'b0; bus.rem1_i = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_arith();
        test_corner();
        test_early();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
